memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Memory stage of the 5-stage RV64 pipeline, and the consumer of execute's output.
- Registers the execute result and issues loads/stores on the data bus (dbus) using a valid/data_ok handshake.
- Aligns and extends load data, then presents a memory_data_t to writeback.
- Drives forwardM, the MEM-stage forwarding source for decode.

Parameters:
- BUS_BYTES, 8, dbus data width in bytes; strobe width equals BUS_BYTES.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  dataE is valid
- in_ready  output  1  stage can accept dataE this cycle
- dataE  input  execute_data_t  pc, ctl, result_alu (address or ALU result), wd (store data), wa
- flush  input  1  kill the instruction held in this stage
- out_valid  output  1  dataM is valid
- out_ready  input  1  writeback accepts dataM
- dataM  output  memory_data_t  pc, ctl, result (final writeback value), wa, misalign
- forwardM  output  forward_data_t  wa, result, regwrite
- dreq  output  dbus_req_t  valid, addr, size, strobe, data
- dresp  input  dbus_resp_t  data_ok, data

Behaviour:
Reset: resetn low asynchronously forces the following.
- State is IDLE.
- in_ready=1, out_valid=0, dreq.valid=0, dreq.strobe=0.
- dataM and forwardM are all zero, so forwardM.regwrite=0.

Accept rule:
- in_ready = (state==IDLE) or (state==DONE and out_ready).
- A transfer occurs when in_valid and in_ready; dataE is then captured into the internal register.

FSM states: IDLE, BUSY, DONE.
- IDLE/DONE + transfer, non-memory op: go to DONE. dataM.result = result_alu. Latency is 1 cycle.
- IDLE/DONE + transfer, memory op, misaligned: go to DONE with misalign=1 and regwrite forced to 0. No bus request is issued.
- IDLE/DONE + transfer, memory op, aligned: go to BUSY. dreq.valid rises the next cycle.
- BUSY: dreq is held constant until dresp.data_ok. On data_ok, go to DONE and latch the extended load data. Stores go to DONE with result = result_alu.
- DONE with out_ready and no transfer: go to IDLE.

Misalignment rule: addr[0] set for half; addr[1:0] nonzero for word; addr[2:0] nonzero for double.

Address and size:
- dreq.addr = result_alu.
- dreq.size comes from ctl.msize (MSIZE1/2/4/8).

Store encoding:
- Strobe = size mask shifted left by addr[2:0]. Mask is 0x01, 0x03, 0x0F or 0xFF.
- dreq.data = wd shifted left by addr[2:0]*8.
- Load requests drive strobe=0.

Load extension:
- Raw value = dresp.data >> (addr[2:0]*8), truncated to size.
- Sign-extended unless ctl.memunsigned.
- Double-word loads pass through unchanged.

Forwarding:
- forwardM.regwrite = out_valid and ctl.regwrite and wa!=0.
- forwardM.result = dataM.result; forwardM.wa = dataM.wa.
- While BUSY, forwardM.regwrite=0 and in_ready=0, so upstream stalls.

Flush:
- In IDLE or DONE: out_valid drops to 0 the next cycle.
- In BUSY: the bus transaction cannot be aborted. dreq stays held and a killed flag is set. On data_ok, go to IDLE with no output.
- Flush together with a transfer: the incoming instruction is dropped.

Simultaneous events:
- data_ok and flush in the same cycle is treated as killed.
- A DONE drain and a new accept in the same cycle are back-to-back with no bubble.

Decomposition:
- Shared pipes package:
  - memory_data_t.
  - ctl fields msize, memread, memwrite, memunsigned.
  - msize_t enum MSIZE1/2/4/8.
- Shared common package: dbus_req_t, dbus_resp_t.
- Sub-module readdata: combinational load align/extend, taking raw data, addr[2:0], msize and unsigned, and returning word_t.
- A strobe/data generator is kept inline.

Test Plan:
- Non-memory op (result_alu=0x1234, wa=5, regwrite=1), out_ready=1 -> next cycle out_valid=1, dataM.result=0x1234, forwardM.regwrite=1, forwardM.wa=5; dreq.valid stays 0.
- Load byte, addr=0x8003, data_ok after 3 cycles with data=0x00000000_80000000 -> dreq.valid held 3 cycles with strobe=0; then dataM.result=0xFFFFFFFF_FFFFFF80. With memunsigned the result is 0x80.
- Store half at addr=0x106, wd=0xBEEF -> dreq.strobe=0xC0, dreq.data[63:48]=0xBEEF, size=MSIZE2; DONE after data_ok with regwrite=0.
- Load word at addr=0x102 -> no dreq.valid; one cycle later out_valid=1, misalign=1, forwardM.regwrite=0.
- Flush asserted 1 cycle into a 4-cycle load -> dreq unchanged until data_ok; afterwards out_valid stays 0 and the next instruction is accepted.
- resetn pulsed low mid-BUSY -> outputs are zero immediately; after release the stage is IDLE with in_ready=1.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared pipeline and data-bus types for the memory stage.
// Also holds the alignment helper used when an instruction is accepted.
package memory_access_pkg;

  localparam int DBUS_BYTES = 8;

  typedef logic [63:0] word_t;
  typedef logic [4:0]  creg_addr_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memunsigned;
    msize_t msize;
  } control_t;

  typedef struct packed {
    word_t      pc;
    control_t   ctl;
    word_t      result_alu;
    word_t      wd;
    creg_addr_t wa;
  } execute_data_t;

  typedef struct packed {
    word_t      pc;
    control_t   ctl;
    word_t      result;
    creg_addr_t wa;
    logic       misalign;
  } memory_data_t;

  typedef struct packed {
    creg_addr_t wa;
    word_t      result;
    logic       regwrite;
  } forward_data_t;

  typedef struct packed {
    logic                    valid;
    word_t                   addr;
    msize_t                  size;
    logic [DBUS_BYTES-1:0]   strobe;
    logic [8*DBUS_BYTES-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                    data_ok;
    logic [8*DBUS_BYTES-1:0] data;
  } dbus_resp_t;

  // An access is misaligned when its low address bits are not a multiple of its size.
  function automatic logic is_misaligned(input logic [2:0] offset, input msize_t msize);
    logic mis;
    mis = 1'b0;
    case (msize)
      MSIZE2:  mis = offset[0];
      MSIZE4:  mis = |offset[1:0];
      MSIZE8:  mis = |offset;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_readdata.sv
// Load data alignment and extension: selects the addressed bytes of a bus
// beat and sign- or zero-extends them to a full register word.
module readdata
  import memory_access_pkg::*;
(
  input  word_t       raw,
  input  logic [2:0]  offset,
  input  msize_t      msize,
  input  logic        is_unsigned,
  output word_t       data
);

  word_t shifted;

  always_comb begin
    shifted = raw >> {offset, 3'b000};
    data    = shifted;
    case (msize)
      MSIZE1:  data = is_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      MSIZE2:  data = is_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      MSIZE4:  data = is_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: holds the execute result, runs one dbus transaction per
// memory op, and presents the final writeback value plus the MEM forward path.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int BUS_BYTES = DBUS_BYTES
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  execute_data_t dataE,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output memory_data_t  dataM,
  output forward_data_t forwardM,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]               state;
  execute_data_t            held;
  logic                     killed;
  logic                     transfer;
  logic                     is_mem;
  logic                     misalign_in;
  logic [BUS_BYTES-1:0]     size_mask;
  logic [BUS_BYTES-1:0]     strobe;
  logic [8*BUS_BYTES-1:0]   wdata;
  word_t                    load_data;
  memory_data_t             accept_data;
  memory_data_t             done_data;

  assign in_ready    = (state == IDLE) || (state == DONE && out_ready);
  assign transfer    = in_valid && in_ready;
  assign out_valid   = (state == DONE);
  assign is_mem      = dataE.ctl.memread || dataE.ctl.memwrite;
  assign misalign_in = is_misaligned(dataE.result_alu[2:0], dataE.ctl.msize);

  readdata u_readdata (
    .raw         (dresp.data),
    .offset      (held.result_alu[2:0]),
    .msize       (held.ctl.msize),
    .is_unsigned (held.ctl.memunsigned),
    .data        (load_data)
  );

  // Store lanes: a size-wide byte mask and the store data moved to the addressed lane.
  always_comb begin
    size_mask = BUS_BYTES'((16'd1 << (4'd1 << held.ctl.msize)) - 16'd1);
    strobe    = size_mask << held.result_alu[2:0];
    wdata     = held.wd << {held.result_alu[2:0], 3'b000};
  end

  always_comb begin
    dreq        = '0;
    dreq.valid  = (state == BUSY);
    dreq.addr   = held.result_alu;
    dreq.size   = held.ctl.msize;
    dreq.strobe = (state == BUSY && held.ctl.memwrite) ? strobe : '0;
    dreq.data   = wdata;
  end

  // A misaligned access completes without touching the bus and must never write a register.
  always_comb begin
    accept_data          = '0;
    accept_data.pc       = dataE.pc;
    accept_data.ctl      = dataE.ctl;
    accept_data.result   = dataE.result_alu;
    accept_data.wa       = dataE.wa;
    accept_data.misalign = is_mem && misalign_in;
    if (is_mem && misalign_in) accept_data.ctl.regwrite = 1'b0;

    done_data          = '0;
    done_data.pc       = held.pc;
    done_data.ctl      = held.ctl;
    done_data.result   = held.ctl.memread ? load_data : held.result_alu;
    done_data.wa       = held.wa;
    done_data.misalign = 1'b0;
  end

  // A bus transaction in flight cannot be aborted, so a flush only marks it killed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      held   <= '0;
      killed <= 1'b0;
      dataM  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (flush) begin
            state <= IDLE;
          end else if (transfer) begin
            held <= dataE;
            if (is_mem && !misalign_in) begin
              state <= BUSY;
            end else begin
              state <= DONE;
              dataM <= accept_data;
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (dresp.data_ok) begin
            killed <= 1'b0;
            if (killed || flush) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              dataM <= done_data;
            end
          end else if (flush) begin
            killed <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    forwardM          = '0;
    forwardM.wa       = dataM.wa;
    forwardM.result   = dataM.result;
    forwardM.regwrite = out_valid && dataM.ctl.regwrite && (dataM.wa != 5'd0);
  end

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for the memory stage against a transaction-level model
// of the load/store, alignment, flush and handshake rules.
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  execute_data_t dataE;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  memory_data_t  dataM;
  forward_data_t forwardM;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;

  int total = 0;
  int bad   = 0;

  memory_access #(.BUS_BYTES(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataE     (dataE),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataM     (dataM),
    .forwardM  (forwardM),
    .dreq      (dreq),
    .dresp     (dresp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bytes of the bus beat starting at the address offset, extended to 64 bits.
  function automatic logic [63:0] model_load(input logic [63:0] bus, input logic [63:0] addr,
                                             input int nbytes, input bit uns);
    logic [63:0] v;
    logic [63:0] m;
    v = bus >> (8 * (addr % 8));
    if (nbytes == 8) return v;
    m = (64'd1 << (8 * nbytes)) - 64'd1;
    v = v & m;
    if (!uns && v[8*nbytes-1]) v = v | ~m;
    return v;
  endfunction

  // Called at negedge+1; returns at negedge+1 with out_ready high so the next call can follow back-to-back.
  task automatic applyStimulus(input int kind, input int sz, input logic [63:0] addr,
                               input logic [63:0] wd, input bit uns, input bit rw,
                               input logic [4:0] wa, input int lat, input int flush_at,
                               input int stall, input logic [63:0] bus);
    int          nbytes;
    bit          mem;
    bit          mis;
    bit          killed;
    logic [63:0] pc;
    logic [63:0] exp_res;
    logic [15:0] strobe_wide;
    logic [7:0]  exp_strobe;
    nbytes      = 1 << sz;
    mem         = (kind != 0);
    mis         = mem && ((addr % nbytes) != 0);
    killed      = 1'b0;
    pc          = {$urandom, $urandom};
    strobe_wide = ((16'd1 << nbytes) - 16'd1) << (addr % 8);
    exp_strobe  = (kind == 2) ? strobe_wide[7:0] : 8'h00;

    in_valid                = 1'b1;
    out_ready               = 1'b1;
    flush                   = 1'b0;
    dataE.pc                = pc;
    dataE.ctl.regwrite      = rw;
    dataE.ctl.memread       = (kind == 1);
    dataE.ctl.memwrite      = (kind == 2);
    dataE.ctl.memunsigned   = uns;
    dataE.ctl.msize         = msize_t'(sz);
    dataE.result_alu        = addr;
    dataE.wd                = wd;
    dataE.wa                = wa;
    #1;
    checkOutput("accept_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dataE    = '0;
    #1;

    if (mem && !mis) begin
      for (int c = 0; c < lat; c++) begin
        checkOutput("dreq_valid", dreq.valid, 1);
        checkOutput("dreq_addr", dreq.addr, addr);
        checkOutput("dreq_size", 64'(dreq.size), 64'(sz));
        checkOutput("dreq_strobe", dreq.strobe, exp_strobe);
        if (kind == 2) checkOutput("dreq_data", dreq.data, wd << (8 * (addr % 8)));
        checkOutput("busy_out_valid", out_valid, 0);
        checkOutput("busy_in_ready", in_ready, 0);
        checkOutput("busy_fwd_regwrite", forwardM.regwrite, 0);
        if (c == flush_at) begin
          flush  = 1'b1;
          killed = 1'b1;
        end
        if (c == lat - 1) begin
          dresp.data_ok = 1'b1;
          dresp.data    = bus;
        end
        @(posedge clk);
        @(negedge clk);
        flush         = 1'b0;
        dresp.data_ok = 1'b0;
        dresp.data    = '0;
        #1;
      end
    end else if (flush_at == 0) begin
      flush  = 1'b1;
      killed = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      #1;
    end

    if (killed) begin
      checkOutput("killed_out_valid", out_valid, 0);
      checkOutput("killed_in_ready", in_ready, 1);
      checkOutput("killed_fwd_regwrite", forwardM.regwrite, 0);
    end else begin
      exp_res = (kind == 1) ? model_load(bus, addr, nbytes, uns) : addr;
      for (int s = 0; s <= stall; s++) begin
        checkOutput("out_valid", out_valid, 1);
        if (!mis) begin
          checkOutput("result", dataM.result, exp_res);
          checkOutput("fwd_result", forwardM.result, exp_res);
        end
        checkOutput("misalign", dataM.misalign, mis);
        checkOutput("wa", dataM.wa, wa);
        checkOutput("fwd_wa", forwardM.wa, wa);
        checkOutput("pc", dataM.pc, pc);
        checkOutput("fwd_regwrite", forwardM.regwrite, rw && !mis && (wa != 5'd0));
        checkOutput("done_dreq_valid", dreq.valid, 0);
        if (s < stall) begin
          out_ready = 1'b0;
          #1;
          checkOutput("stall_in_ready", in_ready, 0);
          @(posedge clk);
          @(negedge clk);
          #1;
        end
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          kind;
    int          sz;
    int          lat;
    int          flush_at;
    logic [63:0] addr;

    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    dataE     = '0;
    dresp     = '0;
    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_dreq_valid", dreq.valid, 0);
    checkOutput("rst_dreq_strobe", dreq.strobe, 0);
    checkOutput("rst_dataM_zero", 64'(|dataM), 0);
    checkOutput("rst_forward_zero", 64'(|forwardM), 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;

    applyStimulus(0, 3, 64'h1234, 64'h0, 1'b0, 1'b1, 5'd5, 1, -1, 0, 64'h0);
    checkOutput("dir_nonmem_result", dataM.result, 64'h1234);
    checkOutput("dir_nonmem_fwd", forwardM.regwrite, 1);
    applyStimulus(0, 3, 64'h5678, 64'h0, 1'b0, 1'b1, 5'd6, 1, -1, 0, 64'h0);
    checkOutput("dir_back_to_back", dataM.result, 64'h5678);
    applyStimulus(1, 0, 64'h8003, 64'h0, 1'b0, 1'b1, 5'd7, 3, -1, 0, 64'h0000_0000_8000_0000);
    checkOutput("dir_lb", dataM.result, 64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(1, 0, 64'h8003, 64'h0, 1'b1, 1'b1, 5'd7, 3, -1, 1, 64'h0000_0000_8000_0000);
    checkOutput("dir_lbu", dataM.result, 64'h80);
    applyStimulus(2, 1, 64'h106, 64'hBEEF, 1'b0, 1'b0, 5'd0, 2, -1, 0, 64'h0);
    checkOutput("dir_sh_fwd", forwardM.regwrite, 0);
    applyStimulus(1, 2, 64'h102, 64'h0, 1'b0, 1'b1, 5'd8, 1, -1, 0, 64'h0);
    checkOutput("dir_lw_misalign", dataM.misalign, 1);
    applyStimulus(1, 3, 64'h200, 64'h0, 1'b0, 1'b1, 5'd9, 4, 1, 0, 64'h1122_3344_5566_7788);
    applyStimulus(0, 3, 64'h42, 64'h0, 1'b0, 1'b1, 5'd10, 1, -1, 0, 64'h0);
    checkOutput("dir_after_kill", dataM.result, 64'h42);

    // Flush arriving with a transfer drops the incoming instruction.
    in_valid         = 1'b1;
    dataE            = '0;
    dataE.result_alu = 64'h99;
    dataE.wa         = 5'd3;
    dataE.ctl.regwrite = 1'b1;
    flush            = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    dataE    = '0;
    #1;
    checkOutput("flush_drop_out_valid", out_valid, 0);
    checkOutput("flush_drop_in_ready", in_ready, 1);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      sz   = $urandom_range(0, 3);
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
      lat      = $urandom_range(1, 5);
      flush_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat - 1) : -1;
      applyStimulus(kind, sz, addr, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), lat, flush_at,
                    $urandom_range(0, 2), {$urandom, $urandom});
    end

    // Reset in the middle of a store transaction.
    in_valid           = 1'b1;
    dataE              = '0;
    dataE.ctl.memwrite = 1'b1;
    dataE.ctl.msize    = MSIZE8;
    dataE.result_alu   = 64'h40;
    dataE.wd           = 64'hDEAD_BEEF_0123_4567;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dataE    = '0;
    #1;
    checkOutput("pre_rst_busy", dreq.valid, 1);
    checkOutput("pre_rst_strobe", dreq.strobe, 8'hFF);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_dreq_valid", dreq.valid, 0);
    checkOutput("mid_rst_strobe", dreq.strobe, 0);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_dataM_zero", 64'(|dataM), 0);
    checkOutput("mid_rst_forward_zero", 64'(|forwardM), 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_out_valid", out_valid, 0);
    checkOutput("post_rst_dreq_valid", dreq.valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
